// File: rtl/fifo_sync_if.sv
// rtl/fifo_sync_if.sv - handshake/status bundle between a fifo_sync and its user
// Purpose: groups every non-clock, non-reset signal of fifo_sync.
// Ports (signals):
//   flush, clr_err                control inputs to the FIFO
//   wr_en, din                    write side
//   rd_en, dout, dout_valid       read side
//   full, almost_full, empty,
//   almost_empty, count           occupancy status
//   overflow, underflow           sticky error flags
// Modports: master drives requests (user side), slave is the FIFO side.
interface fifo_sync_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic             flush;
  logic             clr_err;
  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             full;
  logic             almost_full;
  logic             empty;
  logic             almost_empty;
  logic [DEPTH:0]   count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, clr_err, wr_en, din, rd_en,
    input  dout, dout_valid, full, almost_full, empty, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, wr_en, din, rd_en,
    output dout, dout_valid, full, almost_full, empty, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock FIFO with occupancy count, almost flags, FWFT option, sticky errors
// Purpose: same-domain buffering of WIDTH-bit words, capacity 2**DEPTH, register-array storage.
// Ports:
//   clk  in   clock, all state on posedge
//   rst  in   asynchronous reset, active-high
//   bus  fifo_sync_if.slave
//        in : flush, clr_err, wr_en, din, rd_en
//        out: dout, dout_valid, full, almost_full, empty, almost_empty,
//             count (DEPTH+1 bits), overflow, underflow
module fifo_sync #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic       clk,
  input  logic       rst,
  fifo_sync_if.slave bus
);
  localparam int             CAP      = 1 << DEPTH;
  localparam logic [DEPTH:0] CAP_W    = (DEPTH + 1)'(CAP);
  localparam logic [DEPTH:0] AFULL_W  = (DEPTH + 1)'(AFULL_TH);
  localparam logic [DEPTH:0] AEMPTY_W = (DEPTH + 1)'(AEMPTY_TH);
  localparam logic [DEPTH:0] PTR_ONE  = (DEPTH + 1)'(1);

  logic [WIDTH-1:0] mem [CAP];

  // One extra pointer bit distinguishes full from empty when addresses match.
  logic [DEPTH:0]   wr_ptr;
  logic [DEPTH:0]   rd_ptr;
  logic [DEPTH:0]   occ;
  logic [DEPTH-1:0] wr_addr;
  logic [DEPTH-1:0] rd_addr;
  logic             is_full;
  logic             is_empty;
  logic             wr_acc;
  logic             rd_acc;
  logic             ovf_set;
  logic             unf_set;
  logic             overflow_q;
  logic             underflow_q;

  assign occ      = wr_ptr - rd_ptr;
  assign wr_addr  = wr_ptr[DEPTH-1:0];
  assign rd_addr  = rd_ptr[DEPTH-1:0];
  assign is_full  = (occ == CAP_W);
  assign is_empty = (occ == '0);

  // Acceptance looks only at this cycle's flags, so a read can never make
  // room for a same-cycle write at full (and vice versa at empty).
  // Flush overrides both requests and suppresses error reporting.
  assign wr_acc  = bus.wr_en & ~is_full  & ~bus.flush;
  assign rd_acc  = bus.rd_en & ~is_empty & ~bus.flush;
  assign ovf_set = bus.wr_en & is_full  & ~bus.flush;
  assign unf_set = bus.rd_en & is_empty & ~bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_addr] <= bus.din;
  end

  // A new error event wins over clr_err arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (ovf_set)          overflow_q  <= 1'b1;
      else if (bus.clr_err) overflow_q  <= 1'b0;
      if (unf_set)          underflow_q <= 1'b1;
      else if (bus.clr_err) underflow_q <= 1'b0;
    end
  end

  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.almost_full  = (occ >= AFULL_W);
  assign bus.almost_empty = (occ <= AEMPTY_W);
  assign bus.count        = occ;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always on dout; rd_en just retires it.
      assign bus.dout       = mem[rd_addr];
      assign bus.dout_valid = ~is_empty;
    end else begin : g_std
      logic [WIDTH-1:0] dout_q;
      logic             dout_valid_q;

      // dout holds its last value between reads and across flush.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q       <= '0;
          dout_valid_q <= 1'b0;
        end else begin
          dout_valid_q <= rd_acc;
          if (rd_acc) dout_q <= mem[rd_addr];
        end
      end

      assign bus.dout       = dout_q;
      assign bus.dout_valid = dout_valid_q;
    end
  endgenerate
endmodule

// File: tb/tb_fifo_sync.sv
// tb/tb_fifo_sync.sv - self-checking bench for fifo_sync in standard and FWFT modes
module tb_fifo_sync;
  logic clk;
  logic rst;

  fifo_sync_if #(.WIDTH(8), .DEPTH(4)) if0 ();
  fifo_sync_if #(.WIDTH(8), .DEPTH(4)) if1 ();

  fifo_sync #(.WIDTH(8), .DEPTH(4), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );
  fifo_sync #(.WIDTH(8), .DEPTH(4), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );

  assign if1.flush   = if0.flush;
  assign if1.clr_err = if0.clr_err;
  assign if1.wr_en   = if0.wr_en;
  assign if1.din     = if0.din;
  assign if1.rd_en   = if0.rd_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of stored words plus error/readout state.
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic       m_dv  = 1'b0;
  logic [7:0] m_dout = 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_dv   = 1'b0;
      m_dout = 8'h00;
    end else if (if0.flush) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_dv  = 1'b0;
    end else begin
      int  n;
      logic wa, ra;
      n  = q.size();
      wa = if0.wr_en && (n < 16);
      ra = if0.rd_en && (n > 0);
      if (if0.wr_en && !wa) m_ovf = 1'b1;
      else if (if0.clr_err) m_ovf = 1'b0;
      if (if0.rd_en && !ra) m_unf = 1'b1;
      else if (if0.clr_err) m_unf = 1'b0;
      m_dv = ra;
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(if0.din);
    end
  end

  always @(negedge clk) begin
    int n;
    n = q.size();
    check("count",        32'(if0.count),        32'(n));
    check("full",         32'(if0.full),         32'(n == 16));
    check("empty",        32'(if0.empty),        32'(n == 0));
    check("almost_full",  32'(if0.almost_full),  32'(n >= 14));
    check("almost_empty", 32'(if0.almost_empty), 32'(n <= 2));
    check("overflow",     32'(if0.overflow),     32'(m_ovf));
    check("underflow",    32'(if0.underflow),    32'(m_unf));
    check("dout_valid",   32'(if0.dout_valid),   32'(m_dv));
    check("dout",         32'(if0.dout),         32'(m_dout));
    check("fwft_count",   32'(if1.count),        32'(n));
    check("fwft_valid",   32'(if1.dout_valid),   32'(n > 0));
    if (n > 0) check("fwft_dout", 32'(if1.dout), 32'(q[0]));
  end

  // Drive one cycle of requests; returns 1 time unit after the edge that took them.
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic f, input logic c);
    if0.wr_en   = w;
    if0.din     = d;
    if0.rd_en   = r;
    if0.flush   = f;
    if0.clr_err = c;
    @(posedge clk);
    #1;
    if0.wr_en   = 1'b0;
    if0.rd_en   = 1'b0;
    if0.flush   = 1'b0;
    if0.clr_err = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    if0.wr_en   = 1'b0;
    if0.din     = 8'h00;
    if0.rd_en   = 1'b0;
    if0.flush   = 1'b0;
    if0.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_count", 32'(if0.count), 0);
    check("rst_empty", 32'(if0.empty), 1);
    check("rst_aempty", 32'(if0.almost_empty), 1);
    check("rst_dout", 32'(if0.dout), 0);

    // Fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      if (i == 13) check("t1_afull_13", 32'(if0.almost_full), 0);
      if (i == 14) check("t1_afull_14", 32'(if0.almost_full), 1);
      if (i == 15) check("t1_full_15", 32'(if0.full), 0);
    end
    check("t1_full", 32'(if0.full), 1);
    check("t1_count", 32'(if0.count), 16);

    // Drain in order
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("t2_dout", 32'(if0.dout), 32'(i));
      check("t2_dv", 32'(if0.dout_valid), 1);
      if (i == 13) check("t2_aempty_3", 32'(if0.almost_empty), 0);
      if (i == 14) check("t2_aempty_2", 32'(if0.almost_empty), 1);
    end
    check("t2_empty", 32'(if0.empty), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("t2_dv_pulse", 32'(if0.dout_valid), 0);
    check("t2_dout_hold", 32'(if0.dout), 32'h10);

    // Boundary acceptance and sticky errors
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    check("t3_full_rw_count", 32'(if0.count), 15);
    check("t3_overflow", 32'(if0.overflow), 1);
    check("t3_full_rw_dout", 32'(if0.dout), 32'h20);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    check("t3_empty_rw_count", 32'(if0.count), 1);
    check("t3_underflow", 32'(if0.underflow), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("t3_clr_ovf", 32'(if0.overflow), 0);
    check("t3_clr_unf", 32'(if0.underflow), 0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("t3_pop55", 32'(if0.dout), 32'h55);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    check("t3_set_beats_clr", 32'(if0.underflow), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("t3_clr_again", 32'(if0.underflow), 0);

    // Steady streaming at count 5 across pointer wrap
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 1'b0);
    check("t4_count", 32'(if0.count), 5);
    check("t4_last_dout", 32'(if0.dout), 32'h62);

    // Show-ahead behaviour
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("t5_flushed", 32'(if1.empty), 1);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    check("t5_fwft_dout", 32'(if1.dout), 32'hAA);
    check("t5_fwft_dv", 32'(if1.dout_valid), 1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("t5_fwft_empty", 32'(if1.empty), 1);
    check("t5_fwft_dv_off", 32'(if1.dout_valid), 0);
    check("t5_std_dout", 32'(if0.dout), 32'hAA);

    // Flush with a concurrent write, then async reset mid-burst
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
    check("t6_count9", 32'(if0.count), 9);
    step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
    check("t6_flush_count", 32'(if0.count), 0);
    check("t6_flush_ovf", 32'(if0.overflow), 0);
    check("t6_flush_unf", 32'(if0.underflow), 0);
    check("t6_flush_dv", 32'(if0.dout_valid), 0);
    check("t6_flush_hold", 32'(if0.dout), 32'hAA);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    if0.wr_en = 1'b1;
    if0.din   = 8'h7F;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_count", 32'(if0.count), 0);
    check("t6_rst_empty", 32'(if0.empty), 1);
    check("t6_rst_dout", 32'(if0.dout), 0);
    check("t6_rst_dv", 32'(if0.dout_valid), 0);
    if0.wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t6_post_count", 32'(if0.count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
